// File: rtl/apb_master.sv
// APB master: IDLE/SETUP/ACCESS sequencer for four slaves at 0x1000_0000.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES.
module apb_master #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        transfer,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic [31:0] PADDR,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  output logic        PENABLE,
  output logic        PSEL0,
  output logic        PSEL1,
  output logic        PSEL2,
  output logic        PSEL3,
  input  logic [31:0] PRDATA0,
  input  logic [31:0] PRDATA1,
  input  logic [31:0] PRDATA2,
  input  logic [31:0] PRDATA3,
  input  logic        PREADY0,
  input  logic        PREADY1,
  input  logic        PREADY2,
  input  logic        PREADY3
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  state_e      state_q, state_d;
  logic [31:0] paddr_q, paddr_d;
  logic        pwrite_q, pwrite_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        penable_q, penable_d;
  logic [3:0]  psel_q, psel_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic        pready_sel;
  logic [31:0] prdata_sel;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  // Only the slave addressed by the held PADDR is listened to
  always_comb begin
    pready_sel = 1'b0;
    prdata_sel = '0;
    unique case (paddr_q[13:12])
      2'd0: begin pready_sel = PREADY0; prdata_sel = PRDATA0; end
      2'd1: begin pready_sel = PREADY1; prdata_sel = PRDATA1; end
      2'd2: begin pready_sel = PREADY2; prdata_sel = PRDATA2; end
      default: begin pready_sel = PREADY3; prdata_sel = PRDATA3; end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    penable_d = penable_q;
    psel_d    = psel_q;
    rdata_d   = '0;
    ready_d   = 1'b0;
    err_d     = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        // ready_q blocks acceptance in the completion cycle
        if (transfer && !ready_q) begin
          paddr_d  = addr;
          pwrite_d = write;
          pwdata_d = wdata;
          if (addr[31:14] == 18'h04000) begin
            state_d = SETUP;
            psel_d  = 4'b0001 << addr[13:12];
          end else begin
            ready_d = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ACCESS: begin
        if (pready_sel) begin
          state_d   = IDLE;
          psel_d    = '0;
          penable_d = 1'b0;
          ready_d   = 1'b1;
          rdata_d   = pwrite_q ? '0 : prdata_sel;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = IDLE;
          psel_d    = '0;
          penable_d = 1'b0;
          ready_d   = 1'b1;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_q   <= IDLE;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      penable_q <= 1'b0;
      psel_q    <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      penable_q <= penable_d;
      psel_q    <= psel_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign PADDR   = paddr_q;
  assign PWRITE  = pwrite_q;
  assign PWDATA  = pwdata_q;
  assign PENABLE = penable_q;
  assign PSEL0   = psel_q[0];
  assign PSEL1   = psel_q[1];
  assign PSEL2   = psel_q[2];
  assign PSEL3   = psel_q[3];
  assign rdata   = rdata_q;
  assign ready   = ready_q;
  assign err     = err_q;

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, the number of ACCESS cycles without PREADY before abort (used only with APB_MASTER_TIMEOUT_EN).
REQ-002 SHALL have port PCLK  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port PRESET  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port transfer  input  1  request strobe, sampled only in IDLE.
REQ-005 SHALL have port write  input  1  1 = write, 0 = read; sampled with transfer.
REQ-006 SHALL have port addr  input  32  byte address; sampled with transfer.
REQ-007 SHALL have port wdata  input  32  write data; sampled with transfer.
REQ-008 SHALL have port rdata  output  32  read data, valid while ready=1.
REQ-009 SHALL have port ready  output  1  one-cycle completion pulse.
REQ-010 SHALL have port err  output  1  error flag, valid while ready=1.
REQ-011 SHALL have port PADDR  output  32  APB address.
REQ-012 SHALL have port PWRITE  output  1  APB direction.
REQ-013 SHALL have port PWDATA  output  32  APB write data.
REQ-014 SHALL have port PENABLE  output  1  APB enable.
REQ-015 SHALL have port PSEL0..PSEL3  output  1 each  slave selects.
REQ-016 SHALL have port PRDATA0..PRDATA3  input  32 each  slave read data.
REQ-017 SHALL have port PREADY0..PREADY3  input  1 each  slave ready.

Function
REQ-018 SHALL implement FSM states IDLE, SETUP, ACCESS; all outputs registered.
REQ-019 SHALL, in IDLE with transfer=1, capture addr/write/wdata into PADDR/PWRITE/PWDATA and enter SETUP next cycle; later changes to the inputs are ignored.
REQ-020 SHALL decode addr[31:14]==18'h04000 (0x1000_0000-0x1000_3FFF) as mapped and select slave n = addr[13:12].
REQ-021 SHALL, for an unmapped address, assert no PSEL, return to IDLE, and pulse ready=1 with err=1 and rdata=0 one cycle after acceptance.
REQ-022 SHALL, in SETUP, drive PSELn=1 and PENABLE=0 for exactly one cycle, then enter ACCESS.
REQ-023 SHALL, in ACCESS, hold PSELn=1, PENABLE=1 and PADDR/PWRITE/PWDATA stable until the selected PREADYn=1.
REQ-024 SHALL, on the cycle the selected PREADYn=1 in ACCESS, capture PRDATAn into rdata (reads only; writes leave rdata=0), pulse ready=1 with err=0 next cycle, clear PSEL/PENABLE and return to IDLE.
REQ-025 SHALL ignore PREADY/PRDATA of unselected slaves and all PREADY in IDLE and SETUP.
REQ-026 SHALL give minimum latency of 3 cycles from accepted transfer to ready (SETUP, ACCESS, completion).
REQ-027 SHALL NOT accept a new transfer in the cycle ready=1; back-to-back transfers are issued from the following IDLE cycle.
REQ-028 SHALL drive at most one PSELn high at any time.

Reset
REQ-029 SHALL, while PRESET=0, force state IDLE and all outputs to 0 (PADDR, PWDATA, PWRITE, PENABLE, PSEL0..3, rdata, ready, err), including mid-transfer abort with no completion pulse after release.
REQ-030 SHALL accept a transfer on the first rising edge after PRESET deasserts.

Configuration
REQ-031 SHALL, with APB_MASTER_TIMEOUT_EN defined, count ACCESS cycles and, when TIMEOUT_CYCLES elapse without PREADYn, clear PSEL/PENABLE, pulse ready=1 with err=1 and rdata=0, and return to IDLE.
REQ-032 SHALL, without APB_MASTER_TIMEOUT_EN, contain no timeout counter and wait indefinitely in ACCESS; err is then set only by unmapped addresses.

Verification
REQ-033 SHALL cover: write addr=0x1000_0004 wdata=0xA5 to slave 0 with PREADY0 in first ACCESS -> PSEL0 SETUP 1 cycle, PENABLE 1 cycle, ready pulse 3 cycles after transfer, err=0.
REQ-034 SHALL cover: read addr=0x1000_2000, slave 2 holds PREADY2=0 for 4 ACCESS cycles then returns PRDATA2=0xDEAD_BEEF -> signals stable throughout, rdata=0xDEAD_BEEF, ready 7 cycles after transfer.
REQ-035 SHALL cover: transfer to addr=0x2000_0000 -> no PSEL asserted, ready=1 err=1 rdata=0 one cycle after acceptance.
REQ-036 SHALL cover: PRESET=0 asserted during ACCESS -> all outputs 0 immediately, no ready pulse after release, next transfer completes normally.
REQ-037 SHALL cover: with APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, PREADY1 held 0 -> after 16 ACCESS cycles ready=1 err=1, PSEL1 drops; without macro, still in ACCESS after 100 cycles.
